// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared types and constants for the program counter sequencer
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_TRAP = 2'd2
    } pc_state_t;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] JALR_LSB_MASK    = 32'hFFFF_FFFE;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// rtl/pc_sequencer_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;
    logic             w_full;

    assign w_full  = &r_count;
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_en && !w_full) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencing with EX redirect, stall, halt and misaligned trap
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_DEFAULT,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_ex,
    input  logic             branch_taken,
    input  logic             jalr_ex,
    input  logic [31:0]      pc_ex,
    input  logic [31:0]      imm_ex,
    input  logic [31:0]      rs1_ex,
    input  logic             halt_req,
    input  logic             resume,
    output logic [31:0]      pc_if,
    output logic [31:0]      pc_plus4,
    output logic             fetch_valid,
    output logic             redirect,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             halted,
    output logic             misaligned_trap,
    output logic [31:0]      trap_pc,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] branch_cnt
);

    pc_state_t   r_state;
    pc_state_t   w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_trap_pc;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_run;
    logic        w_take;
    logic        w_redirect;

    assign w_run        = rst_n && (r_state == ST_RUN);
    assign w_target     = jalr_ex ? ((rs1_ex + imm_ex) & JALR_LSB_MASK) : (pc_ex + imm_ex);
    assign w_misaligned = w_target[1];
    assign w_take       = w_run && branch_taken;
    assign w_redirect   = w_take && !w_misaligned;

    // A taken branch squashes the two younger instructions whether it redirects or traps.
    assign redirect        = w_redirect;
    assign flush_ifid      = w_take;
    assign flush_idex      = w_take;
    assign fetch_valid     = w_run;
    assign halted          = (r_state == ST_HALT);
    assign misaligned_trap = (r_state == ST_TRAP);
    assign pc_if           = r_pc;
    assign pc_plus4        = r_pc + PC_INCR;
    assign trap_pc         = r_trap_pc;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            ST_RUN: begin
                if (w_take) begin
                    if (w_misaligned) begin
                        w_state_next = ST_TRAP;
                    end else begin
                        w_pc_next = w_target;
                    end
                end else if (stall) begin
                    w_pc_next = r_pc;
                end else if (halt_req) begin
                    w_state_next = ST_HALT;
                end else begin
                    w_pc_next = r_pc + PC_INCR;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_TRAP: begin
                w_state_next = ST_TRAP;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_pc      <= RESET_VECTOR;
            r_trap_pc <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_take && w_misaligned) begin
                r_trap_pc <= pc_ex;
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_redirect_cnt (
        .i_clk   (clk),
        .i_clear (!rst_n),
        .i_en    (w_redirect),
        .o_count (redirect_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_branch_cnt (
        .i_clk   (clk),
        .i_clear (!rst_n),
        .i_en    (w_run && branch_ex),
        .o_count (branch_cnt)
    );

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the program counter for the pipelined core. Takes the branch/jump decision resolved in EX (branch_taken from the branch comparator) and computes the redirect target. Sequences PC update, stall hold, wrong-path flush, halt/resume and misaligned-target trapping. Sits between the hazard unit, the EX stage and the instruction fetch port.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of the saturating redirect and branch counters

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  synchronous active-low reset
stall  in  1  hazard-unit hold of IF/ID (load-use)
branch_ex  in  1  EX holds a conditional branch (valid instruction)
branch_taken  in  1  comparator result for the EX instruction (already gated by branch/jump)
jalr_ex  in  1  EX instruction is JALR (implies jump)
pc_ex  in  32  PC of the EX instruction
imm_ex  in  32  sign-extended immediate of the EX instruction
rs1_ex  in  32  forwarded rs1 of the EX instruction
halt_req  in  1  level request to halt fetch (EBREAK/debug)
resume  in  1  one-cycle pulse leaving HALT
pc_if  out  32  fetch address (registered)
pc_plus4  out  32  pc_if + 4
fetch_valid  out  1  fetch address is valid this cycle
redirect  out  1  taken branch/jump redirect this cycle
flush_ifid  out  1  squash IF/ID at next edge
flush_idex  out  1  squash ID/EX at next edge
halted  out  1  state == HALT
misaligned_trap  out  1  state == TRAP (sticky)
trap_pc  out  32  pc_ex of the offending instruction
redirect_cnt  out  CNT_W  number of redirects, saturating
branch_cnt  out  CNT_W  conditional branches resolved, saturating

Behaviour:
- Reset (rst_n low at edge): state=RUN, pc_if=RESET_VECTOR, trap_pc=0, both counters=0. Combinational outputs redirect/flush_* forced 0 while rst_n low. Applies from any state, mid-halt or mid-trap included.
- States: RUN, HALT, TRAP. fetch_valid = (state==RUN) && rst_n.
- Target: branch or JAL = pc_ex + imm_ex. JALR = (rs1_ex + imm_ex) & ~32'h1. 32-bit wrap-around, no overflow detection.
- Misaligned: target[1] != 0 while branch_taken in RUN. redirect=0, flush_ifid=flush_idex=1, pc_if holds, trap_pc<=pc_ex, next state TRAP. TRAP exits only via reset.
- Redirect (RUN, branch_taken, target aligned): redirect=1, flush_ifid=flush_idex=1 combinationally in the same cycle. pc_if<=target at the edge. Zero-cycle latency decision, 2-instruction penalty. Redirect overrides stall and halt_req.
- Stall (RUN, no redirect, stall=1): pc_if holds, no flush.
- Normal (RUN, no redirect, no stall, halt_req=0): pc_if<=pc_if+4.
- Halt: halt_req=1 in RUN with no redirect -> pc_if holds, next state HALT. In HALT: pc_if frozen, fetch_valid=0, flushes 0, branch_taken ignored. resume=1 -> RUN next edge; fetch restarts at the frozen pc_if. halt_req and resume together in HALT: resume wins. If halt_req stays high, the core re-halts the cycle after.
- Counters: branch_cnt += 1 when RUN && branch_ex. redirect_cnt += 1 on each redirect cycle. Both saturate at all-ones and never wrap.

Decomposition:
- Shared package: state enum (RUN/HALT/TRAP), RESET_VECTOR default, PC increment constant 4, JALR LSB mask.
- One sub-module: sat_counter (CNT_W, en, clear -> count), instantiated twice.
- Target adder and alignment check stay inline.

Test Plan:
- Reset release, no stimulus, 3 cycles -> pc_if 0x0, 0x4, 0x8. fetch_valid=1 after reset.
- pc_ex=0x100, imm_ex=0xFFFFFFF0, branch_ex=1, branch_taken=1 -> redirect=1, flush_ifid=flush_idex=1 that cycle. pc_if=0xF0 next cycle. redirect_cnt=1, branch_cnt=1.
- jalr_ex=1, rs1_ex=0x203, imm_ex=0x4, taken -> pc_if=0x206 (LSB cleared) is misaligned: TRAP, trap_pc=pc_ex. Repeat with rs1_ex=0x201 -> pc_if=0x204.
- stall=1 and taken branch (target 0x40) in the same cycle -> redirect wins, pc_if=0x40. stall alone for 2 cycles at pc 0x20 -> pc_if stays 0x20.
- halt_req=1 at pc 0x10 -> halted=1, fetch_valid=0, pc_if=0x10 held 5 cycles. resume pulse -> RUN, pc_if=0x14 one cycle later. Reset asserted while in HALT -> pc_if=0x0, RUN.
- Force branch_cnt to all-ones (CNT_W=4 build, 16 branches) -> holds 4'hF on the 17th.
